vga3_interface: RTL
===================

Name: vga3_interface

Overview:
- Parametrised successor to the 1-bit VGA timing generator.
- Generates H/V counters, framebuffer read addresses and a read strobe, sync pulses with configurable polarity, and multi-bit RGB.
- Has a framebuffer-latency compensation pipeline, so sync/blank stay aligned with pixel data returned FetchLatency cycles after the address.
- Sits between the framebuffer RAM and the board VGA DAC pins.

Parameters:
- HAddrSize, 11, width of H counter/address
- HVisibleArea, 800, visible pixels per line
- HFrontPorch, 56, H front porch clocks
- HSyncPulse, 120, H sync clocks
- HBackPorch, 64, H back porch clocks
- VAddrSize, 11, width of V counter/address
- VVisibleArea, 600, visible lines
- VFrontPorch, 37, V front porch lines
- VSyncPulse, 6, V sync lines
- VBackPorch, 23, V back porch lines
- ColorBits, 4, bits per colour channel
- FetchLatency, 1, framebuffer read latency in clocks (legal 0..4)
- HSyncActiveHigh, 0, 1 = hsync asserted high
- VSyncActiveHigh, 0, 1 = vsync asserted high

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- color_r  in  ColorBits  red data for address issued FetchLatency cycles earlier
- color_g  in  ColorBits  green, same timing
- color_b  in  ColorBits  blue, same timing
- fb_addr_h  out  HAddrSize  pixel column; 0 outside visible area
- fb_addr_v  out  VAddrSize  pixel row; 0 outside visible area
- fb_read  out  1  high when fb_addr is a valid visible-pixel request
- line_start  out  1  one-cycle pulse when H counter = 0
- frame_start  out  1  one-cycle pulse when H = 0 and V = 0
- vga_hsync  out  1  registered, polarity per HSyncActiveHigh
- vga_vsync  out  1  registered, polarity per VSyncActiveHigh
- vga_r  out  ColorBits  registered red; 0 when blanked
- vga_g  out  ColorBits  registered green; 0 when blanked
- vga_b  out  ColorBits  registered blue; 0 when blanked

Behaviour:
- HTotal = sum of the 4 H params; VTotal = sum of the 4 V params.
- H counter: 0..HTotal-1, wraps to 0.
- V counter: increments only when H = HTotal-1, wraps after VTotal-1.
- Reset (async assert, sync release) sets:
  - H to HTotal-1 and V to VTotal-1, so the first clock after release shows pixel (0,0) on the request side;
  - all delay-pipe stages to blank/sync-inactive;
  - vga_r/g/b to 0 and vga_hsync/vga_vsync to inactive level.
- Request side, combinational from the counters in cycle t:
  - vis = (H < HVisibleArea) & (V < VVisibleArea);
  - fb_read = vis;
  - fb_addr = counters masked by vis;
  - line_start and frame_start decoded directly; both are 0 while reset is asserted.
- Sync regions:
  - H sync: HVisibleArea+HFrontPorch <= H < HVisibleArea+HFrontPorch+HSyncPulse;
  - V sync: same form on V.
- Delay pipe: {vis, hs, vs} shifts through FetchLatency register stages. FetchLatency = 0 means pass-through.
- Output register: at the edge ending cycle t+FetchLatency, load:
  - vga_r/g/b = color inputs if delayed vis, else 0;
  - vga_hsync = delayed hs XNOR HSyncActiveHigh;
  - vga_vsync = delayed vs XNOR VSyncActiveHigh.
- Total latency from counter value to pins is FetchLatency+1 clocks. Relative sync/colour alignment is identical to the unpipelined case.
- Colour inputs are ignored (masked) whenever delayed vis = 0.
- Reset mid-frame: outputs blank immediately (asynchronously); the pipe is flushed, with no stale pixels after release.
- Counter widths must hold HTotal-1 and VTotal-1; the compare arithmetic uses full counter width.

Optional Feature:
- Macro VGA3_TESTPATTERN_EN.
- Defined:
  - adds input test_mode (1 bit);
  - when high, colour inputs are replaced by 8 vertical bars: bar index = (delayed H * 8) / HVisibleArea; r/g/b = all-ones or 0 per bits 2/1/0 of the index;
  - fb_read is forced 0;
  - the H column is carried through the delay pipe;
  - sync timing is unchanged.
- Undefined: no test_mode port; colour always from the inputs.

Test Plan:
- Small config (H 8/2/3/1, total 14; V 4/1/2/1, total 8; FetchLatency 2). Release reset -> cycle 0 has fb_addr (0,0), fb_read=1, line_start=1, frame_start=1; vga_* still blank until cycle 3.
- Same config, color inputs = fb_addr_h delayed by 2 cycles -> vga_r at cycle t+3 equals H at t for H 0..7; vga_r=0 for H 8..13.
- Active-low sync -> vga_hsync low exactly for request-side H 10..12 (pins 3 cycles later); vga_vsync low for rows 5..6; period 14 and 112 clocks respectively.
- HSyncActiveHigh=1, VSyncActiveHigh=1 -> same windows, levels inverted; idle level after reset is 0.
- Assert reset mid-line at H=5, V=2, with colors all-ones -> outputs drop to 0/inactive in the same cycle without a clock edge; after release, first visible pixel appears 3 cycles later at (0,0).
- Defaults (800x600, total 1040x666) -> frame_start period 692640 clocks; fb_read high 480000 cycles per frame.

Source files
------------

// File: rtl/vga3_interface.sv
// Parametrised VGA timing generator with framebuffer-latency compensation.
// Optional VGA3_TESTPATTERN_EN adds test_mode (8 vertical colour bars).
module vga3_interface #(
  parameter int HAddrSize       = 11,
  parameter int HVisibleArea    = 800,
  parameter int HFrontPorch     = 56,
  parameter int HSyncPulse      = 120,
  parameter int HBackPorch      = 64,
  parameter int VAddrSize       = 11,
  parameter int VVisibleArea    = 600,
  parameter int VFrontPorch     = 37,
  parameter int VSyncPulse      = 6,
  parameter int VBackPorch      = 23,
  parameter int ColorBits       = 4,
  parameter int FetchLatency    = 1,
  parameter int HSyncActiveHigh = 0,
  parameter int VSyncActiveHigh = 0
) (
  input  logic                 clock,
  input  logic                 reset,
`ifdef VGA3_TESTPATTERN_EN
  input  logic                 test_mode,
`endif
  input  logic [ColorBits-1:0] color_r,
  input  logic [ColorBits-1:0] color_g,
  input  logic [ColorBits-1:0] color_b,
  output logic [HAddrSize-1:0] fb_addr_h,
  output logic [VAddrSize-1:0] fb_addr_v,
  output logic                 fb_read,
  output logic                 line_start,
  output logic                 frame_start,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic [ColorBits-1:0] vga_r,
  output logic [ColorBits-1:0] vga_g,
  output logic [ColorBits-1:0] vga_b
);

  localparam int HTotal = HVisibleArea + HFrontPorch
                        + HSyncPulse + HBackPorch;
  localparam int VTotal = VVisibleArea + VFrontPorch
                        + VSyncPulse + VBackPorch;

  localparam logic [HAddrSize-1:0] HLast =
    HAddrSize'(HTotal - 1);
  localparam logic [HAddrSize-1:0] HVis =
    HAddrSize'(HVisibleArea);
  localparam logic [HAddrSize-1:0] HSyncBeg =
    HAddrSize'(HVisibleArea + HFrontPorch);
  localparam logic [HAddrSize-1:0] HSyncEnd =
    HAddrSize'(HVisibleArea + HFrontPorch + HSyncPulse - 1);

  localparam logic [VAddrSize-1:0] VLast =
    VAddrSize'(VTotal - 1);
  localparam logic [VAddrSize-1:0] VVis =
    VAddrSize'(VVisibleArea);
  localparam logic [VAddrSize-1:0] VSyncBeg =
    VAddrSize'(VVisibleArea + VFrontPorch);
  localparam logic [VAddrSize-1:0] VSyncEnd =
    VAddrSize'(VVisibleArea + VFrontPorch + VSyncPulse - 1);

  localparam logic HPol = (HSyncActiveHigh != 0);
  localparam logic VPol = (VSyncActiveHigh != 0);

  logic [HAddrSize-1:0] h;
  logic [VAddrSize-1:0] v;
  logic                 vis;
  logic                 hs;
  logic                 vs;
  logic                 vis_dl;
  logic                 hs_dl;
  logic                 vs_dl;
  logic [ColorBits-1:0] pix_r;
  logic [ColorBits-1:0] pix_g;
  logic [ColorBits-1:0] pix_b;

  // Reset parks on the last pixel so the first edge lands on (0,0).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h <= HLast;
      v <= VLast;
    end else if (h == HLast) begin
      h <= '0;
      v <= (v == VLast) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign vis = (h < HVis) && (v < VVis);
  assign hs  = (h >= HSyncBeg) && (h <= HSyncEnd);
  assign vs  = (v >= VSyncBeg) && (v <= VSyncEnd);

  assign fb_addr_h   = vis ? h : '0;
  assign fb_addr_v   = vis ? v : '0;
  assign line_start  = reset && (h == '0);
  assign frame_start = line_start && (v == '0);

`ifdef VGA3_TESTPATTERN_EN
  logic [HAddrSize-1:0] h_dl;
  logic [HAddrSize+2:0] bar_full;
  logic [2:0]           bar;

  assign fb_read  = vis && !test_mode;
  assign bar_full = {h_dl, 3'b000}
                  / (HAddrSize+3)'(HVisibleArea);
  assign bar      = bar_full[2:0];
`else
  assign fb_read = vis;
`endif

  generate
    if (FetchLatency == 0) begin : g_nopipe
      assign vis_dl = vis;
      assign hs_dl  = hs;
      assign vs_dl  = vs;
`ifdef VGA3_TESTPATTERN_EN
      assign h_dl   = h;
`endif
    end else begin : g_pipe
      logic [FetchLatency-1:0] vis_q;
      logic [FetchLatency-1:0] hs_q;
      logic [FetchLatency-1:0] vs_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          vis_q <= '0;
          hs_q  <= '0;
          vs_q  <= '0;
        end else begin
          vis_q[0] <= vis;
          hs_q[0]  <= hs;
          vs_q[0]  <= vs;
          for (int i = 1; i < FetchLatency; i++) begin
            vis_q[i] <= vis_q[i-1];
            hs_q[i]  <= hs_q[i-1];
            vs_q[i]  <= vs_q[i-1];
          end
        end
      end

      assign vis_dl = vis_q[FetchLatency-1];
      assign hs_dl  = hs_q[FetchLatency-1];
      assign vs_dl  = vs_q[FetchLatency-1];

`ifdef VGA3_TESTPATTERN_EN
      logic [HAddrSize-1:0] h_q [FetchLatency];

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < FetchLatency; i++)
            h_q[i] <= '0;
        end else begin
          h_q[0] <= h;
          for (int i = 1; i < FetchLatency; i++)
            h_q[i] <= h_q[i-1];
        end
      end

      assign h_dl = h_q[FetchLatency-1];
`endif
    end
  endgenerate

  always_comb begin
    pix_r = color_r;
    pix_g = color_g;
    pix_b = color_b;
`ifdef VGA3_TESTPATTERN_EN
    if (test_mode) begin
      pix_r = {ColorBits{bar[2]}};
      pix_g = {ColorBits{bar[1]}};
      pix_b = {ColorBits{bar[0]}};
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
      vga_hsync <= ~HPol;
      vga_vsync <= ~VPol;
    end else begin
      vga_r     <= vis_dl ? pix_r : '0;
      vga_g     <= vis_dl ? pix_g : '0;
      vga_b     <= vis_dl ? pix_b : '0;
      vga_hsync <= ~(hs_dl ^ HPol);
      vga_vsync <= ~(vs_dl ^ VPol);
    end
  end

endmodule
